// File: rtl/nec_pkg.sv
// nec_pkg -- shared definitions for the NEC IR receiver.
//   state_t    : receiver FSM states
//   *_US       : nominal NEC symbol durations in microseconds
//   nec_bound  : converts a nominal duration and a percentage into a cycle count
//   nec_in_win : inclusive window test for a measured interval
`timescale 1ns/1ps
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_PULSE,
    LEAD_SPACE,
    BIT_PULSE,
    BIT_SPACE,
    CHECK
  } state_t;

  localparam longint unsigned LEAD_PULSE_US = 64'd9000;
  localparam longint unsigned LEAD_SPACE_US = 64'd4500;
  localparam longint unsigned RPT_SPACE_US  = 64'd2250;
  localparam longint unsigned BIT_PULSE_US  = 64'd562;
  localparam longint unsigned BIT0_SPACE_US = 64'd562;
  localparam longint unsigned BIT1_SPACE_US = 64'd1687;
  localparam longint unsigned STOP_PULSE_US = 64'd562;

  // Cycles = nom_us * clk_hz * pct / (100 * 1e6), truncated; clamps to the
  // 24-bit interval counter range so a saturated count can never alias a bound.
  function automatic logic [23:0] nec_bound(input longint unsigned nom_us,
                                            input longint unsigned clk_hz,
                                            input longint unsigned pct);
    longint unsigned v;
    v = (nom_us * clk_hz * pct) / 64'd100_000_000;
    if (v > 64'hFF_FFFF) v = 64'hFF_FFFF;
    return v[23:0];
  endfunction

  function automatic logic nec_in_win(input logic [23:0] t,
                                      input logic [23:0] lo,
                                      input logic [23:0] hi);
    return (t >= lo) && (t <= hi);
  endfunction

endpackage

// File: rtl/nec_envelope.sv
// nec_envelope -- input synchroniser and carrier envelope detector.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ir_in : raw carrier-modulated IR line (asynchronous)
//   env   : high while carrier edges keep arriving; drops after
//           HOLD = 2*CLK_FREQ/CARRIER_FREQ cycles without an edge
`timescale 1ns/1ps
module nec_envelope #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int CARRIER_FREQ = 38_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_in,
  output logic env
);

  localparam int          HOLD      = (2 * CLK_FREQ) / CARRIER_FREQ;
  localparam logic [23:0] HOLD_LAST = (HOLD > 1) ? 24'(HOLD - 1) : 24'd0;

  logic [1:0]  sync_reg;
  logic        ir_d_reg;
  logic        env_reg;
  logic [23:0] hold_reg;
  logic        edge_seen;

  // ir_d_reg trails the synchroniser output by one cycle to expose edges.
  assign edge_seen = sync_reg[1] ^ ir_d_reg;
  assign env       = env_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      ir_d_reg <= 1'b0;
      env_reg  <= 1'b0;
      hold_reg <= 24'd0;
    end else begin
      sync_reg <= {sync_reg[0], ir_in};
      ir_d_reg <= sync_reg[1];
      if (edge_seen) begin
        env_reg  <= 1'b1;
        hold_reg <= 24'd0;
      end else if (env_reg) begin
        if (hold_reg >= HOLD_LAST) env_reg <= 1'b0;
        else                       hold_reg <= hold_reg + 24'd1;
      end
    end
  end

endmodule

// File: rtl/nec_receiver.sv
// nec_receiver -- NEC infrared frame decoder.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ir_in      : carrier-modulated IR line
//   addr, cmd  : bytes of the last accepted frame (update with valid)
//   valid      : one-cycle strobe for an accepted frame
//   err        : one-cycle strobe for an aborted or malformed frame
//   busy       : FSM not in IDLE
//   rpt        : one-cycle repeat-code strobe (only with NEC_REPEAT_EN)
// Build option: define NEC_REPEAT_EN to add the rpt port and repeat-code path.
`timescale 1ns/1ps
module nec_receiver import nec_pkg::*; #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int CARRIER_FREQ = 38_000,
  parameter int TOL_PCT      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       err,
  output logic       busy
`ifdef NEC_REPEAT_EN
  ,
  output logic       rpt
`endif
);

  localparam longint unsigned CLK = 64'(CLK_FREQ);
  localparam longint unsigned PLO = 64'(100 - TOL_PCT);
  localparam longint unsigned PHI = 64'(100 + TOL_PCT);

  localparam logic [23:0] LP_LO = nec_bound(LEAD_PULSE_US, CLK, PLO);
  localparam logic [23:0] LP_HI = nec_bound(LEAD_PULSE_US, CLK, PHI);
  localparam logic [23:0] LS_LO = nec_bound(LEAD_SPACE_US, CLK, PLO);
  localparam logic [23:0] LS_HI = nec_bound(LEAD_SPACE_US, CLK, PHI);
  localparam logic [23:0] BP_LO = nec_bound(BIT_PULSE_US,  CLK, PLO);
  localparam logic [23:0] BP_HI = nec_bound(BIT_PULSE_US,  CLK, PHI);
  localparam logic [23:0] B0_LO = nec_bound(BIT0_SPACE_US, CLK, PLO);
  localparam logic [23:0] B0_HI = nec_bound(BIT0_SPACE_US, CLK, PHI);
  localparam logic [23:0] B1_LO = nec_bound(BIT1_SPACE_US, CLK, PLO);
  localparam logic [23:0] B1_HI = nec_bound(BIT1_SPACE_US, CLK, PHI);
  localparam logic [23:0] SP_LO = nec_bound(STOP_PULSE_US, CLK, PLO);
  localparam logic [23:0] SP_HI = nec_bound(STOP_PULSE_US, CLK, PHI);
  // No legal space is longer than the upper lead-space bound.
  localparam logic [23:0] TMO   = LS_HI;
`ifdef NEC_REPEAT_EN
  localparam logic [23:0] RS_LO = nec_bound(RPT_SPACE_US, CLK, PLO);
  localparam logic [23:0] RS_HI = nec_bound(RPT_SPACE_US, CLK, PHI);
`endif

  logic        env;
  logic        env_d_reg;
  logic        rise, fall;
  logic [23:0] cnt_reg;
  state_t      state_reg, state_next;
  logic [31:0] shift_reg, shift_next;
  logic [5:0]  idx_reg, idx_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic        rpt_pend_reg, rpt_pend_next;
  logic        timeout;
  logic        pair_ok;
  logic        last_pulse;
`ifdef NEC_REPEAT_EN
  logic        seen_reg, seen_next;
  logic        rpt_hit;
`endif

  nec_envelope #(
    .CLK_FREQ    (CLK_FREQ),
    .CARRIER_FREQ(CARRIER_FREQ)
  ) u_env (
    .clk  (clk),
    .rst_n(rst_n),
    .ir_in(ir_in),
    .env  (env)
  );

  assign rise = env & ~env_d_reg;
  assign fall = ~env & env_d_reg;

  // Only low intervals (spaces) can time out; the counter saturates so a
  // stuck line keeps reporting an over-long interval instead of wrapping.
  assign timeout = ((state_reg == LEAD_SPACE) || (state_reg == BIT_SPACE)) &&
                   !env_d_reg && (cnt_reg > TMO);

  assign pair_ok = (shift_reg[23:16] == ~shift_reg[31:24]) &&
                   (shift_reg[7:0]   == ~shift_reg[15:8]);

  // A pulse closes a frame after 32 bits, or directly after a repeat space.
  assign last_pulse = (idx_reg == 6'd32) || rpt_pend_reg;

  assign busy = (state_reg != IDLE);
  assign addr = addr_next;
  assign cmd  = cmd_next;
`ifdef NEC_REPEAT_EN
  assign rpt  = rpt_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_d_reg    <= 1'b0;
      cnt_reg      <= 24'd0;
      state_reg    <= IDLE;
      shift_reg    <= 32'd0;
      idx_reg      <= 6'd0;
      addr_reg     <= 8'd0;
      cmd_reg      <= 8'd0;
      rpt_pend_reg <= 1'b0;
`ifdef NEC_REPEAT_EN
      seen_reg     <= 1'b0;
`endif
    end else begin
      env_d_reg <= env;
      if (rise || fall)          cnt_reg <= 24'd0;
      else if (cnt_reg != '1)    cnt_reg <= cnt_reg + 24'd1;
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      idx_reg      <= idx_next;
      addr_reg     <= addr_next;
      cmd_reg      <= cmd_next;
      rpt_pend_reg <= rpt_pend_next;
`ifdef NEC_REPEAT_EN
      seen_reg     <= seen_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    idx_next      = idx_reg;
    addr_next     = addr_reg;
    cmd_next      = cmd_reg;
    rpt_pend_next = rpt_pend_reg;
    valid         = 1'b0;
    err           = 1'b0;
`ifdef NEC_REPEAT_EN
    seen_next     = seen_reg;
    rpt_hit       = 1'b0;
`endif
    if (timeout) begin
      // Any edge in this same cycle is deliberately dropped.
      err        = 1'b1;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) state_next = LEAD_PULSE;
        end
        LEAD_PULSE: begin
          if (fall) begin
            if (nec_in_win(cnt_reg, LP_LO, LP_HI)) state_next = LEAD_SPACE;
            else begin
              err        = 1'b1;
              state_next = IDLE;
            end
          end
        end
        LEAD_SPACE: begin
          if (rise) begin
            if (nec_in_win(cnt_reg, LS_LO, LS_HI)) begin
              state_next    = BIT_PULSE;
              idx_next      = 6'd0;
              rpt_pend_next = 1'b0;
`ifdef NEC_REPEAT_EN
            end else if (nec_in_win(cnt_reg, RS_LO, RS_HI)) begin
              state_next    = BIT_PULSE;
              rpt_pend_next = 1'b1;
`endif
            end else begin
              err        = 1'b1;
              state_next = IDLE;
            end
          end
        end
        BIT_PULSE: begin
          if (fall) begin
            if (last_pulse && nec_in_win(cnt_reg, SP_LO, SP_HI))
              state_next = CHECK;
            else if (!last_pulse && nec_in_win(cnt_reg, BP_LO, BP_HI))
              state_next = BIT_SPACE;
            else begin
              err        = 1'b1;
              state_next = IDLE;
            end
          end
        end
        BIT_SPACE: begin
          if (rise) begin
            if (nec_in_win(cnt_reg, B0_LO, B0_HI) || nec_in_win(cnt_reg, B1_LO, B1_HI)) begin
              shift_next = {shift_reg[30:0], nec_in_win(cnt_reg, B1_LO, B1_HI)};
              idx_next   = idx_reg + 6'd1;
              state_next = BIT_PULSE;
            end else begin
              err        = 1'b1;
              state_next = IDLE;
            end
          end
        end
        CHECK: begin
          state_next = IDLE;
          if (rpt_pend_reg) begin
`ifdef NEC_REPEAT_EN
            // A repeat code is meaningless until some frame has been accepted.
            if (seen_reg) rpt_hit = 1'b1;
            else          err     = 1'b1;
`else
            err = 1'b1;
`endif
          end else if (pair_ok) begin
            valid     = 1'b1;
            addr_next = shift_reg[31:24];
            cmd_next  = shift_reg[15:8];
`ifdef NEC_REPEAT_EN
            seen_next = 1'b1;
`endif
          end else begin
            err = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_receiver.sv
// tb_nec_receiver -- scoreboard bench for nec_receiver.
// Runs the receiver at a 100 kHz clock with a true 38 kHz carrier so that
// whole frames fit in a short run; expected events are queued as stimulus is
// driven and matched against valid/err/rpt strobes. Honours NEC_REPEAT_EN.
`timescale 1ns/1ps
module tb_nec_receiver;

  localparam int CLK_HZ   = 100_000;
  localparam int CAR_HZ   = 38_000;
  localparam int CYC_NS   = 1_000_000_000 / CLK_HZ;
  localparam int HALF_NS  = 1_000_000_000 / (2 * CAR_HZ);
  localparam int HOLD     = (2 * CLK_HZ) / CAR_HZ;
  localparam int TMO_CYC  = (5625 * CLK_HZ) / 1_000_000;

  typedef struct {
    int         kind;   // 0 valid, 1 err, 2 rpt
    logic [7:0] a;
    logic [7:0] c;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_in = 1'b0;
  logic [7:0] addr, cmd;
  logic       valid, err, busy;
  logic       rpt_w;

  int   n_total = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  logic [7:0] m_addr = 8'd0;
  logic [7:0] m_cmd  = 8'd0;

  always #(CYC_NS / 2) clk = ~clk;

  nec_receiver #(
    .CLK_FREQ    (CLK_HZ),
    .CARRIER_FREQ(CAR_HZ),
    .TOL_PCT     (25)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ir_in(ir_in),
    .addr (addr),
    .cmd  (cmd),
    .valid(valid),
    .err  (err),
    .busy (busy)
`ifdef NEC_REPEAT_EN
    ,
    .rpt  (rpt_w)
`endif
  );

`ifndef NEC_REPEAT_EN
  assign rpt_w = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_valid(input logic [7:0] a, input logic [7:0] c);
    m_addr = a;
    m_cmd  = c;
    exp_q.push_back('{kind: 0, a: a, c: c});
  endtask

  task automatic exp_err();
    exp_q.push_back('{kind: 1, a: m_addr, c: m_cmd});
  endtask

  task automatic exp_rpt();
    exp_q.push_back('{kind: 2, a: m_addr, c: m_cmd});
  endtask

  // Carrier burst of 'us' microseconds; the line is left low afterwards.
  task automatic burst(input int us);
    int total;
    int el;
    total = us * 1000;
    el = 0;
    ir_in = 1'b1;
    while (el + HALF_NS <= total) begin
      #(HALF_NS);
      el += HALF_NS;
      ir_in = ~ir_in;
    end
    ir_in = 1'b0;
    #(total - el);
  endtask

  task automatic space(input int us);
    ir_in = 1'b0;
    #(us * 1000);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      burst(562);
      space(w[31 - i] ? 1687 : 562);
    end
  endtask

  // Lead, 32 data bits and stop pulse; returns at the end of the stop burst.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    burst(9000);
    space(4500);
    send_bits({b0, b1, b2, b3}, 32);
    burst(562);
  endtask

  // Counts falling clock edges until the chosen strobe (0 valid, 1 err) is seen.
  task automatic wait_for(input int which, input int max_cyc, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      hit = (which == 0) ? valid : err;
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    int  kind;
    if (valid || err || rpt_w) begin
      kind = valid ? 0 : (err ? 1 : 2);
      $display("event kind=%0d addr=%02h cmd=%02h t=%0t", kind, addr, cmd, $time);
      chk("valid_err_excl", {31'd0, valid & err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", kind, 32'hFF);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_addr", {24'd0, addr}, {24'd0, e.a});
        chk("event_cmd",  {24'd0, cmd},  {24'd0, e.c});
      end
    end
  end

  initial begin : watchdog
    #(1_000_000_000);
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    // reset state
    repeat (4) @(negedge clk);
    chk("rst_addr",  {24'd0, addr}, 32'd0);
    chk("rst_cmd",   {24'd0, cmd},  32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    rst_n = 1'b1;
    space(2000);

    // good frame, with stop-to-valid latency
    exp_valid(8'h5A, 8'h3C);
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    wait_for(0, 200, n);
    $display("frame 5A/3C valid after %0d cycles", n);
    chk("stop_to_valid_lat", {31'd0, (n >= HOLD + 1) && (n <= HOLD + 7)}, 32'd1);
    space(3000);

    // inverted-address byte wrong: err, outputs hold
    exp_err();
    send_frame(8'h5A, 8'hA4, 8'h3C, 8'hC3);
    space(3000);
    chk("hold_addr", {24'd0, addr}, 32'h5A);
    chk("hold_cmd",  {24'd0, cmd},  32'h3C);

    // short 6 ms lead, then a good frame
    exp_err();
    burst(6000);
    space(3000);
    exp_valid(8'h12, 8'h34);
    send_frame(8'h12, 8'hED, 8'h34, 8'hCB);
    space(3000);

    // line stuck low after bit 12
    exp_err();
    burst(9000);
    space(4500);
    send_bits(32'h9E61_55AA, 12);
    burst(562);
    wait_for(1, 3000, n);
    $display("stuck-low err after %0d cycles", n);
    chk("timeout_lat", {31'd0, (n >= TMO_CYC + HOLD) && (n <= TMO_CYC + HOLD + 10)}, 32'd1);
    @(negedge clk);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    space(14000);

    // reset in the middle of bit 20, then a good frame
    burst(9000);
    space(4500);
    send_bits(32'hC33C_A55A, 20);
    burst(200);
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    m_addr = 8'd0;
    m_cmd  = 8'd0;
    chk("midrst_addr", {24'd0, addr}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    space(3000);
    exp_valid(8'h01, 8'hFF);
    send_frame(8'h01, 8'hFE, 8'hFF, 8'h00);
    space(3000);

    // repeat code: 9 ms lead, 2.25 ms space, stop pulse
`ifdef NEC_REPEAT_EN
    exp_rpt();
`else
    exp_err();
`endif
    burst(9000);
    space(2250);
    burst(562);
    space(3000);
    chk("post_rpt_addr", {24'd0, addr}, {24'd0, m_addr});
    chk("post_rpt_cmd",  {24'd0, cmd},  {24'd0, m_cmd});

    space(2000);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
